pipelined_datapath: RTL and testbench

Parametrised 5-stage pipelined successor of the single-cycle uPOWER/MIPS datapath. It accepts one instruction per cycle over a valid/ready handshake and moves it through ID, EX, MEM and WB pipeline registers. It resolves data hazards with EX/MEM and MEM/WB forwarding, a register-file write-through bypass and a one-cycle load-use stall. It sits under the processor top level, fed by the instruction-fetch block, and exposes its writeback stream for checking.

---
 rtl/pipelined_datapath.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_pipelined_datapath.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_datapath.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_datapath
// Purpose  : Five-stage (IF/ID, ID/EX, EX/MEM, MEM/WB) in-order integer
//            pipeline for a MIPS-format subset: add, sub, and, or, slt,
//            addi, lw, sw. Data hazards are resolved with EX/MEM and MEM/WB
//            forwarding, a register-file write-through bypass and a
//            one-cycle load-use stall.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous active-low reset
//            in_instr     - instruction word offered by fetch
//            in_valid     - in_instr is valid this cycle
//            in_ready     - pipeline accepts in_instr at this edge
//            wb_valid     - retiring instruction writes a register
//            wb_reg       - destination register of the retiring instruction
//            wb_data      - value written back
//            err_illegal  - one-cycle pulse: unsupported instruction in EX
//            retire_count - retired instructions (sw and illegal included)
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_datapath #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     in_instr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wb_valid,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data,
  output logic            err_illegal,
  output logic [31:0]     retire_count
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // Architectural storage (element views driven from per-entry flops below)
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] mem  [MEM_DEPTH];

  // IF/ID
  logic            ifid_valid;
  logic [31:0]     ifid_instr;

  // ID/EX
  logic            idex_valid;
  alu_op_t         idex_alu;
  logic            idex_use_imm;
  logic            idex_is_lw;
  logic            idex_is_sw;
  logic            idex_wreg;
  logic            idex_illegal;
  logic [RW-1:0]   idex_dest;
  logic [RW-1:0]   idex_rs;
  logic [RW-1:0]   idex_rt;
  logic [XLEN-1:0] idex_rs_val;
  logic [XLEN-1:0] idex_rt_val;
  logic [XLEN-1:0] idex_imm;

  // EX/MEM
  logic            exmem_valid;
  logic [XLEN-1:0] exmem_result;
  logic [XLEN-1:0] exmem_store;
  logic [RW-1:0]   exmem_dest;
  logic            exmem_wreg;
  logic            exmem_is_lw;
  logic            exmem_is_sw;
  logic            exmem_illegal;

  // MEM/WB
  logic            memwb_valid;
  logic            memwb_wreg;
  logic [RW-1:0]   memwb_dest;
  logic [XLEN-1:0] memwb_data;

  // Decode
  logic [5:0]      dec_op;
  logic [5:0]      dec_funct;
  logic [RW-1:0]   dec_rs;
  logic [RW-1:0]   dec_rt;
  logic [RW-1:0]   dec_rd;
  logic [RW-1:0]   dec_dest;
  logic [XLEN-1:0] dec_imm;
  logic            dec_legal;
  logic            dec_writes;
  logic            dec_wreg;
  logic            dec_use_imm;
  logic            dec_is_lw;
  logic            dec_is_sw;
  logic            dec_uses_rt;
  alu_op_t         dec_alu;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            wb_write;
  logic            stall;

  // Execute / memory
  logic            ex_fwd_ok;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_reg;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_out;

  // --------------------------------------------------------------------------
  // Decode and register read
  // --------------------------------------------------------------------------
  always_comb begin
    dec_op      = ifid_instr[31:26];
    dec_funct   = ifid_instr[5:0];
    dec_rs      = ifid_instr[21 +: RW];
    dec_rt      = ifid_instr[16 +: RW];
    dec_rd      = ifid_instr[11 +: RW];
    dec_imm     = XLEN'($signed(ifid_instr[15:0]));
    dec_legal   = 1'b0;
    dec_writes  = 1'b0;
    dec_use_imm = 1'b0;
    dec_is_lw   = 1'b0;
    dec_is_sw   = 1'b0;
    dec_uses_rt = 1'b0;
    dec_dest    = dec_rd;
    dec_alu     = ALU_ADD;
    case (dec_op)
      OP_RTYPE: begin
        dec_uses_rt = 1'b1;
        dec_legal   = 1'b1;
        dec_writes  = 1'b1;
        case (dec_funct)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_SLT:  dec_alu = ALU_SLT;
          default: begin
            dec_legal  = 1'b0;
            dec_writes = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_legal   = 1'b1;
        dec_writes  = 1'b1;
        dec_use_imm = 1'b1;
        dec_dest    = dec_rt;
      end
      OP_LW: begin
        dec_legal   = 1'b1;
        dec_writes  = 1'b1;
        dec_use_imm = 1'b1;
        dec_is_lw   = 1'b1;
        dec_dest    = dec_rt;
      end
      OP_SW: begin
        dec_legal   = 1'b1;
        dec_use_imm = 1'b1;
        dec_is_sw   = 1'b1;
        dec_uses_rt = 1'b1;
      end
      default: ;
    endcase
    // r0 writes are dropped here so every later stage can trust wreg alone
    dec_wreg = dec_writes && (dec_dest != '0);
  end

  assign wb_write = memwb_valid && memwb_wreg;

  // Write-through: a read colliding with this cycle's writeback sees new data
  assign rs_val = (wb_write && (memwb_dest == dec_rs)) ? memwb_data : regs[dec_rs];
  assign rt_val = (wb_write && (memwb_dest == dec_rt)) ? memwb_data : regs[dec_rt];

  // Load result is only available after MEM, one cycle too late for a
  // directly following consumer in EX.
  assign stall = ifid_valid && idex_valid && idex_is_lw && idex_wreg &&
                 ((idex_dest == dec_rs) || (dec_uses_rt && (idex_dest == dec_rt)));

  assign in_ready = !stall;

  // --------------------------------------------------------------------------
  // Execute with forwarding
  // --------------------------------------------------------------------------
  // A load in EX/MEM has no data yet; the stall guarantees nobody needs it.
  assign ex_fwd_ok = exmem_valid && exmem_wreg && !exmem_is_lw;

  always_comb begin
    if (ex_fwd_ok && (exmem_dest == idex_rs))
      op_a = exmem_result;
    else if (wb_write && (memwb_dest == idex_rs))
      op_a = memwb_data;
    else
      op_a = idex_rs_val;

    if (ex_fwd_ok && (exmem_dest == idex_rt))
      op_b_reg = exmem_result;
    else if (wb_write && (memwb_dest == idex_rt))
      op_b_reg = memwb_data;
    else
      op_b_reg = idex_rt_val;

    alu_b   = idex_use_imm ? idex_imm : op_b_reg;
    alu_res = '0;
    case (idex_alu)
      ALU_ADD: alu_res = op_a + alu_b;
      ALU_SUB: alu_res = op_a - alu_b;
      ALU_AND: alu_res = op_a & alu_b;
      ALU_OR:  alu_res = op_a | alu_b;
      ALU_SLT: alu_res[0] = ($signed(op_a) < $signed(alu_b));
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory stage
  // --------------------------------------------------------------------------
  assign mem_addr = exmem_result[AW-1:0];
  assign mem_out  = exmem_is_lw ? mem[mem_addr] : exmem_result;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      idex_valid    <= 1'b0;
      idex_alu      <= ALU_ADD;
      idex_use_imm  <= 1'b0;
      idex_is_lw    <= 1'b0;
      idex_is_sw    <= 1'b0;
      idex_wreg     <= 1'b0;
      idex_illegal  <= 1'b0;
      idex_dest     <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rs_val   <= '0;
      idex_rt_val   <= '0;
      idex_imm      <= '0;
      exmem_valid   <= 1'b0;
      exmem_result  <= '0;
      exmem_store   <= '0;
      exmem_dest    <= '0;
      exmem_wreg    <= 1'b0;
      exmem_is_lw   <= 1'b0;
      exmem_is_sw   <= 1'b0;
      exmem_illegal <= 1'b0;
      memwb_valid   <= 1'b0;
      memwb_wreg    <= 1'b0;
      memwb_dest    <= '0;
      memwb_data    <= '0;
    end else begin
      // IF/ID holds its instruction while stalled
      if (!stall) begin
        ifid_valid <= in_valid;
        ifid_instr <= in_instr;
      end

      idex_valid   <= ifid_valid && !stall;
      idex_alu     <= dec_alu;
      idex_use_imm <= dec_use_imm;
      idex_is_lw   <= dec_is_lw;
      idex_is_sw   <= dec_is_sw;
      idex_wreg    <= dec_wreg;
      idex_illegal <= !dec_legal;
      idex_dest    <= dec_dest;
      idex_rs      <= dec_rs;
      idex_rt      <= dec_rt;
      idex_rs_val  <= rs_val;
      idex_rt_val  <= rt_val;
      idex_imm     <= dec_imm;

      exmem_valid   <= idex_valid;
      exmem_result  <= alu_res;
      exmem_store   <= op_b_reg;
      exmem_dest    <= idex_dest;
      exmem_wreg    <= idex_wreg;
      exmem_is_lw   <= idex_is_lw;
      exmem_is_sw   <= idex_is_sw;
      exmem_illegal <= idex_valid && idex_illegal;

      memwb_valid <= exmem_valid;
      memwb_wreg  <= exmem_wreg;
      memwb_dest  <= exmem_dest;
      memwb_data  <= mem_out;
    end
  end

  // --------------------------------------------------------------------------
  // Register file and data memory; each entry resets to its own index
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREG; gi++) begin : g_regfile
    logic [XLEN-1:0] entry;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        entry <= XLEN'(gi);
      else if (wb_write && (memwb_dest == RW'(gi)))
        entry <= memwb_data;
    end
    assign regs[gi] = entry;
  end

  for (genvar gm = 0; gm < MEM_DEPTH; gm++) begin : g_dmem
    logic [XLEN-1:0] word;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        word <= XLEN'(gm);
      else if (exmem_valid && exmem_is_sw && (mem_addr == AW'(gm)))
        word <= exmem_store;
    end
    assign mem[gm] = word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_count <= '0;
    else if (memwb_valid)
      retire_count <= retire_count + 32'd1;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wb_valid    = wb_write;
  assign wb_reg      = 5'(memwb_dest);
  assign wb_data     = memwb_data;
  assign err_illegal = exmem_illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_datapath
// Purpose  : Self-checking bench for pipelined_datapath. An architectural
//            (in-order, one-instruction-at-a-time) model computes each
//            instruction's effect at acceptance and schedules when its
//            writeback, error pulse and retirement must appear. A compare
//            process checks every cycle; directed sequences pin literal
//            results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        err_illegal;
  logic [31:0] retire_count;

  pipelined_datapath #(.XLEN(32), .NREG(32), .MEM_DEPTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_instr     (in_instr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .err_illegal  (err_illegal),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- model
  typedef struct {
    int          err_edge;
    int          wb_edge;
    int          ret_edge;
    bit          wv;
    bit          ill;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    int          e;
    logic [4:0]  r;
    logic [31:0] d;
  } obs_t;

  ent_t        pend[$];
  obs_t        obs[$];
  logic [31:0] mr [32];
  logic [31:0] mm [32];
  int          cyc = 0;
  bit          pred_ready = 1'b1;
  bit          id_v = 1'b0;
  bit          ex_v = 1'b0;
  logic [31:0] id_i = '0;
  logic [31:0] ex_i = '0;
  bit          exp_wbv = 1'b0;
  bit          exp_err = 1'b0;
  bit          exp_rst = 1'b1;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_ret = '0;
  int          n_err = 0;
  int          n_stall = 0;

  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rt, input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Sequential ISA semantics applied in program order.
  task automatic model_exec(input logic [31:0] ins);
    ent_t        e;
    logic [31:0] a, b, imm, val, addr;
    int          dest;
    bit          wr, ill;
    a    = mr[ins[25:21]];
    b    = mr[ins[20:16]];
    imm  = {{16{ins[15]}}, ins[15:0]};
    addr = a + imm;
    val  = '0;
    dest = 0;
    wr   = 1'b0;
    ill  = 1'b0;
    case (ins[31:26])
      6'd0: begin
        dest = int'(ins[15:11]);
        wr   = 1'b1;
        case (ins[5:0])
          6'd32:   val = a + b;
          6'd34:   val = a - b;
          6'd36:   val = a & b;
          6'd37:   val = a | b;
          6'd42:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; ill = 1'b1; end
        endcase
      end
      6'd8:  begin dest = int'(ins[20:16]); wr = 1'b1; val = a + imm; end
      6'd35: begin dest = int'(ins[20:16]); wr = 1'b1; val = mm[addr[4:0]]; end
      6'd43: mm[addr[4:0]] = b;
      default: ill = 1'b1;
    endcase
    e.wv = wr && (dest != 0);
    if (e.wv) mr[dest] = val;
    e.ill      = ill;
    e.rd       = 5'(dest);
    e.data     = val;
    e.err_edge = cyc + 2;
    e.wb_edge  = cyc + 3;
    e.ret_edge = cyc + 4;
    pend.push_back(e);
  endtask

  function automatic bit hazard();
    logic [4:0] lr;
    bit         id_uses_rt;
    lr         = ex_i[20:16];
    id_uses_rt = (id_i[31:26] == 6'd0) || (id_i[31:26] == 6'd43);
    return id_v && ex_v && (ex_i[31:26] == 6'd35) && (lr != 5'd0) &&
           ((lr == id_i[25:21]) || (id_uses_rt && (lr == id_i[20:16])));
  endfunction

  always @(posedge clk) begin
    cyc++;
    exp_wbv = 1'b0;
    exp_err = 1'b0;
    if (!rst_n) begin
      pend.delete();
      for (int i = 0; i < 32; i++) begin
        mr[i] = 32'(i);
        mm[i] = 32'(i);
      end
      exp_ret    = '0;
      exp_reg    = '0;
      exp_data   = '0;
      exp_rst    = 1'b1;
      id_v       = 1'b0;
      ex_v       = 1'b0;
      pred_ready = 1'b1;
    end else begin
      exp_rst = 1'b0;
      if (!pred_ready) begin
        // The stalled instruction is the newest one; it slips a cycle.
        ex_v = 1'b0;
        if (pend.size() > 0) begin
          ent_t t;
          t = pend.pop_back();
          t.err_edge++;
          t.wb_edge++;
          t.ret_edge++;
          pend.push_back(t);
        end
      end else begin
        ex_v = id_v;
        ex_i = id_i;
        id_v = in_valid;
        id_i = in_instr;
        if (in_valid) model_exec(in_instr);
      end
      foreach (pend[j]) begin
        if (pend[j].err_edge == cyc && pend[j].ill) exp_err = 1'b1;
        if (pend[j].wb_edge == cyc) begin
          exp_wbv  = pend[j].wv;
          exp_reg  = pend[j].rd;
          exp_data = pend[j].data;
        end
        if (pend[j].ret_edge == cyc) exp_ret = exp_ret + 32'd1;
      end
      while (pend.size() > 0 && pend[0].ret_edge <= cyc) void'(pend.pop_front());
      pred_ready = !hazard();
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #3;
    chk("in_ready", 32'(in_ready), 32'(pred_ready));
    chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
    if (exp_wbv || exp_rst) begin
      chk("wb_reg", 32'(wb_reg), 32'(exp_reg));
      chk("wb_data", wb_data, exp_data);
    end
    chk("err_illegal", 32'(err_illegal), 32'(exp_err));
    chk("retire_count", retire_count, exp_ret);
    if (wb_valid) begin
      obs_t o;
      o.e = cyc;
      o.r = wb_reg;
      o.d = wb_data;
      obs.push_back(o);
    end
    if (err_illegal) n_err++;
    if (!in_ready) n_stall++;
  end

  task automatic chk_obs(input int idx, input int r, input logic [31:0] d);
    if (idx >= obs.size()) begin
      checks++;
      errors++;
      $display("FAIL obs_missing: got %0d writebacks, required entry %0d", obs.size(), idx);
    end else begin
      chk("obs_reg", 32'(obs[idx].r), 32'(r));
      chk("obs_data", obs[idx].d, d);
    end
  endtask

  function automatic int gap(input int idx);
    if (idx < 1 || idx >= obs.size()) return -1;
    return obs[idx].e - obs[idx-1].e;
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] ins);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    while (!pred_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    obs.delete();
    n_err   = 0;
    n_stall = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd, sel;
    k   = int'($urandom_range(0, 99));
    rs  = int'($urandom_range(0, 7));
    rt  = int'($urandom_range(0, 7));
    rd  = int'($urandom_range(0, 7));
    sel = int'($urandom_range(0, 4));
    if (k < 35) begin
      case (sel)
        0: return rtype(rd, rs, rt, 32);
        1: return rtype(rd, rs, rt, 34);
        2: return rtype(rd, rs, rt, 36);
        3: return rtype(rd, rs, rt, 37);
        default: return rtype(rd, rs, rt, 42);
      endcase
    end
    if (k < 55) return itype(8, rt, rs, int'($urandom_range(0, 65535)));
    if (k < 70) return itype(35, rt, rs, int'($urandom_range(0, 40)));
    if (k < 85) return itype(43, rt, rs, int'($urandom_range(0, 40)));
    if (k < 93) begin
      case (sel)
        0: return itype(63, rt, rs, 1);
        1: return itype(2, rt, rs, 2);
        2: return itype(4, rt, rs, 3);
        default: return itype(12, rt, rs, 4);
      endcase
    end
    return rtype(rd, rs, rt, (sel < 2) ? 0 : 33);
  endfunction

  initial begin
    // addi r1,r0,5 ; add r2,r1,r1 back to back
    do_reset();
    clear_logs();
    send(itype(8, 1, 0, 5));
    send(rtype(2, 1, 1, 32));
    idle(8);
    chk_obs(0, 1, 32'd5);
    chk_obs(1, 2, 32'd10);
    chk("t1_gap", 32'(gap(1)), 32'd1);
    chk("t1_stalls", 32'(n_stall), 32'd0);

    // lw r3,4(r0) ; add r4,r3,r3 -> single load-use stall
    clear_logs();
    send(itype(35, 3, 0, 4));
    send(rtype(4, 3, 3, 32));
    idle(8);
    chk_obs(0, 3, 32'd4);
    chk_obs(1, 4, 32'd8);
    chk("t2_gap", 32'(gap(1)), 32'd2);
    chk("t2_stalls", 32'(n_stall), 32'd1);

    // sw r2,7(r0) ; lw r5,7(r0)
    do_reset();
    clear_logs();
    send(itype(43, 2, 0, 7));
    send(itype(35, 5, 0, 7));
    idle(8);
    chk_obs(0, 5, 32'd2);
    chk("t3_wb_count", 32'(obs.size()), 32'd1);
    chk("t3_retired", retire_count, 32'd2);

    // sub wraps, signed slt, write to r0 discarded
    do_reset();
    clear_logs();
    send(rtype(6, 1, 2, 34));
    send(rtype(7, 6, 0, 42));
    send(itype(8, 0, 0, 9));
    idle(8);
    chk_obs(0, 6, 32'hFFFF_FFFF);
    chk_obs(1, 7, 32'd1);
    chk("t4_wb_count", 32'(obs.size()), 32'd2);
    chk("t4_retired", retire_count, 32'd3);

    // illegal opcode then an ordinary add
    clear_logs();
    send({6'd63, 26'd0});
    send(rtype(8, 1, 2, 32));
    idle(8);
    chk("t5_err_pulses", 32'(n_err), 32'd1);
    chk_obs(0, 8, 32'd3);
    chk("t5_wb_count", 32'(obs.size()), 32'd1);
    chk("t5_retired", retire_count, 32'd5);

    // reset with three instructions in flight
    send(itype(8, 9, 0, 100));
    send(itype(8, 10, 0, 200));
    send(itype(8, 11, 0, 300));
    do_reset();
    clear_logs();
    send(rtype(9, 9, 0, 32));
    send(itype(35, 12, 0, 20));
    send(rtype(13, 11, 10, 32));
    idle(8);
    chk_obs(0, 9, 32'd9);
    chk_obs(1, 12, 32'd20);
    chk_obs(2, 13, 32'd21);
    chk("t6_retired", retire_count, 32'd3);

    // randomized traffic against the model
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) do_reset();
      if ($urandom_range(0, 9) < 8) send(rand_instr());
      else idle(1);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
